if_stage_prefetch: RTL
======================

Name: if_stage_prefetch

Overview:
Parametrised instruction-fetch stage for the ARM968E-S pipeline. It generates sequential fetch addresses and issues them to a variable-latency instruction memory over a valid/ready request channel with in-order responses. Returned words are buffered in a DEPTH-entry prefetch FIFO that feeds the ID stage. It supports branch redirect with flush and discard of wrong-path in-flight responses, and freeze (ID stall) without losing fetched words.

Parameters:
AW, 32, fetch address / PC width
DW, 32, instruction word width
DEPTH, 4, prefetch FIFO entries and maximum outstanding requests (power of 2, >=2)
INSTR_BYTES, 4, PC increment per instruction
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset (rst==0 at a rising edge resets)
freeze  in  1  ID stall; head entry held, no pop
branch_taken  in  1  redirect request from EXE
branch_address  in  AW  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  AW  fetch address
imem_rsp_valid  in  1  response valid (in order, one per accepted request)
imem_rsp_data  in  DW  response instruction
if_valid  out  1  Instruction/PC valid to ID
Instruction  out  DW  FIFO head instruction
PC  out  AW  FIFO head address + INSTR_BYTES

Behaviour:
- Reset (rst==0 at edge): fetch_pc=RESET_PC, FIFO empty, inflight=0, drop=0. Outputs while in reset and the cycle after: imem_req_valid=0, if_valid=0, Instruction=0, PC=0 (Instruction/PC are 0 whenever FIFO empty).
- Credit rule: live = inflight - drop. imem_req_valid = rst & ~branch_taken & (fifo_count + live < DEPTH). imem_addr = fetch_pc.
- Request accepted on imem_req_valid & imem_req_ready: fetch_pc += INSTR_BYTES (wraps mod 2^AW), inflight += 1.
- Response (imem_rsp_valid): inflight -= 1. If drop>0: drop -= 1, data discarded. Otherwise push {addr_tag, data} to FIFO. The address tag comes from an internal response-address register that advances by INSTR_BYTES per live response and is set to branch_address on redirect. The credit rule guarantees no push into a full FIFO.
- Pop: if_valid & ~freeze. Push and pop in the same cycle are both performed; count unchanged.
- Output latency: a response pushed at edge N appears at the head (if_valid=1) after edge N. Minimum request-to-ID latency is 1 cycle plus memory latency.
- Branch (branch_taken=1 at edge):
  - FIFO flushed (count=0, no pop counted).
  - fetch_pc = branch_address, response tag = branch_address.
  - drop = inflight value after this cycle's response decrement. Any response this cycle is discarded.
  - No request is issued this cycle.
  - The first target request is issued the next cycle.
- Simultaneous events:
  - branch + freeze: branch wins; flush and redirect.
  - branch + rsp: response discarded.
  - freeze with full FIFO: requests stop when fifo_count + live == DEPTH; resume the cycle after a pop frees a credit.
- imem_req_ready low: imem_req_valid and imem_addr held stable until accepted, unless branch_taken deasserts valid. Dropping valid on redirect is legal for this interface.
- Reset mid-operation: all counters cleared. The memory is reset on the same rst, so no stale responses arrive. imem_rsp_valid with inflight==0 is ignored (sim assertion fires).
- Counter widths: inflight/drop are clog2(DEPTH)+1 bits. They never exceed DEPTH.

Decomposition:
- Shared package if_pkg holds INSTR_BYTES, RESET_PC default, and the fetch_entry_t struct {addr AW, instr DW}.
- One sub-module: prefetch_fifo (sync FIFO, DEPTH entries, push/pop/flush, count, full/empty, flush dominates push and pop).
- Fetch/credit/drop control lives in if_stage_prefetch.

Test Plan:
1. Reset, 0-wait memory (ready=1, rsp next cycle), RESET_PC=0 -> imem_addr 0,4,8,... on consecutive cycles; if_valid from cycle 3; PC outputs 4,8,12; Instruction matches mem[0],mem[4],...
2. Memory latency 3, DEPTH=4, freeze=1 throughout -> exactly 4 requests (addr 0..12), then imem_req_valid=0; FIFO fills to 4. Release freeze -> one pop per cycle, request for 16 issued the cycle after the first pop.
3. 2 requests outstanding (addr 8,12), branch_taken with branch_address=0x100 -> next accepted request addr 0x100. The two stale responses are dropped, if_valid stays 0 until mem[0x100] returns, then PC=0x104.
4. branch_taken and freeze together with 3 FIFO entries -> FIFO empty next cycle, no pop counted, fetch_pc=branch_address.
5. imem_req_ready=0 for 5 cycles -> imem_addr stable, valid held, fetch_pc unchanged. After ready=1, sequence continues without a gap or duplicate.
6. rst=0 for one cycle mid-stream with 2 in flight -> next cycle if_valid=0, imem_req_valid=0, then fetch restarts at RESET_PC with no stale instruction delivered.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
`timescale 1ns/1ps
package if_pkg;

    localparam int IF_AW          = 32;
    localparam int IF_DW          = 32;
    localparam int IF_INSTR_BYTES = 4;
    localparam logic [IF_AW-1:0] IF_RESET_PC = '0;

    typedef struct packed {
        logic [IF_AW-1:0] addr;
        logic [IF_DW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_prefetch_fifo.sv
// Synchronous prefetch FIFO; flush dominates push and pop.
`timescale 1ns/1ps
module prefetch_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (PW+1)'(DEPTH));
        do_pop  = pop & ~empty & ~flush;
        do_push = push & (~full | do_pop) & ~flush;
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/if_stage_prefetch.sv
// Fetch stage: credit-limited imem requests, in-order responses into a
// prefetch FIFO, branch redirect with discard of wrong-path responses.
`timescale 1ns/1ps
module if_stage_prefetch
    import if_pkg::*;
#(
    parameter int AW          = IF_AW,
    parameter int DW          = IF_DW,
    parameter int DEPTH       = 4,
    parameter int INSTR_BYTES = IF_INSTR_BYTES,
    parameter logic [AW-1:0] RESET_PC = AW'(IF_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_address,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rsp_valid,
    input  logic [DW-1:0] imem_rsp_data,
    output logic          if_valid,
    output logic [DW-1:0] Instruction,
    output logic [AW-1:0] PC
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] instr;
    } entry_t;

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          run_q, run_d;

    logic [CW-1:0] live;
    logic [CW:0]   credit_sum;
    logic          req_fire, rsp_ok;
    logic          fifo_push, fifo_pop;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    entry_t        push_entry, head;

    always_comb begin
        live           = inflight_q - drop_q;
        credit_sum     = {1'b0, fifo_count} + {1'b0, live};
        // run_q keeps requests off for the first cycle out of reset
        imem_req_valid = rst & run_q & ~branch_taken
                       & (credit_sum < (CW+1)'(DEPTH));
        req_fire       = imem_req_valid & imem_req_ready;
        rsp_ok         = imem_rsp_valid & (inflight_q != '0);
        fifo_push      = rsp_ok & (drop_q == '0) & ~branch_taken;
        fifo_pop       = if_valid & ~freeze & ~branch_taken;
        push_entry     = '{addr: tag_q, instr: imem_rsp_data};

        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        tag_d      = tag_q;
        run_d      = 1'b1;

        if (branch_taken) begin
            drop_d     = inflight_q - CW'(rsp_ok);
            fetch_pc_d = branch_address;
            tag_d      = branch_address;
        end else begin
            if (rsp_ok && drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + AW'(INSTR_BYTES);
            end
            if (fifo_push) begin
                tag_d = tag_q + AW'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            tag_q      <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            run_q      <= run_d;
        end
    end

    prefetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (branch_taken),
        .din   (push_entry),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_addr   = fetch_pc_q;
    assign if_valid    = rst & ~fifo_empty;
    assign Instruction = if_valid ? head.instr : '0;
    assign PC          = if_valid ? head.addr + AW'(INSTR_BYTES) : '0;

    rsp_credit_a: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> inflight_q != '0);

    fifo_room_a: assert property (@(posedge clk) disable iff (!rst)
        fifo_push |-> (!fifo_full || fifo_pop));

endmodule
